// File: rtl/mem_dump_unit.sv
// Walks a range of data-memory words and streams each one to the UART transmitter, MSB byte first.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module mem_dump_unit #(
    parameter int ADDR_BUS  = 11,
    parameter int DATA_SIZE = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [ADDR_BUS-1:0]  Start_Addr,
    input  logic [ADDR_BUS:0]    Count,
    output logic [ADDR_BUS-1:0]  Mem_Addr,
    output logic                 Mem_Rd,
    input  logic [DATA_SIZE-1:0] Mem_Data,
    output logic [7:0]           Tx_Data,
    output logic                 Tx_Start,
    input  logic                 Tx_Done,
    output logic                 Busy,
    output logic                 Done
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_RD_ADDR = 4'd1, S_LATCH = 4'd2, S_SEND_HI = 4'd3, S_WAIT_HI = 4'd4,
        S_SEND_LO = 4'd5, S_WAIT_LO = 4'd6, S_NEXT = 4'd7, S_DONE = 4'd8,
        S_CHK_SEND = 4'd9, S_CHK_WAIT = 4'd10
    } state_t;
    localparam state_t S_FINISH = S_CHK_SEND;
`else
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_RD_ADDR = 4'd1, S_LATCH = 4'd2, S_SEND_HI = 4'd3, S_WAIT_HI = 4'd4,
        S_SEND_LO = 4'd5, S_WAIT_LO = 4'd6, S_NEXT = 4'd7, S_DONE = 4'd8
    } state_t;
    localparam state_t S_FINISH = S_DONE;
`endif

    localparam logic [ADDR_BUS:0]   CNT_ZERO = {(ADDR_BUS+1){1'b0}};
    localparam logic [ADDR_BUS:0]   CNT_ONE  = {{ADDR_BUS{1'b0}}, 1'b1};
    localparam logic [ADDR_BUS-1:0] ADDR_ONE = {{(ADDR_BUS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_BUS-1:0]   addr_q, addr_d;
    logic [ADDR_BUS:0]     remaining_q, remaining_d;
    logic [DATA_SIZE-1:0]  word_q, word_d;
    logic [ADDR_BUS-1:0]   mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = (Count == CNT_ZERO) ? S_FINISH : S_RD_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: state_d = S_LATCH;
            S_LATCH:   state_d = S_SEND_HI;
            S_SEND_HI: state_d = S_WAIT_HI;
            S_WAIT_HI: state_d = Tx_Done ? S_SEND_LO : S_WAIT_HI;
            S_SEND_LO: state_d = S_WAIT_LO;
            S_WAIT_LO: state_d = Tx_Done ? S_NEXT : S_WAIT_LO;
            S_NEXT:    state_d = (remaining_q == CNT_ONE) ? S_FINISH : S_RD_ADDR;
            S_DONE:    state_d = S_IDLE;
`ifdef DUMP_CHECKSUM_EN
            S_CHK_SEND: state_d = S_CHK_WAIT;
            S_CHK_WAIT: state_d = Tx_Done ? S_DONE : S_CHK_WAIT;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Address, word-count and captured-word datapath
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    addr_d      = Start_Addr;
                    remaining_d = Count;
                end else begin
                    addr_d      = addr_q;
                    remaining_d = remaining_q;
                end
            end
            S_LATCH: word_d = Mem_Data;
            S_NEXT: begin
                addr_d      = addr_q + ADDR_ONE;
                remaining_d = remaining_q - CNT_ONE;
            end
            default: word_d = word_q;
        endcase
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every byte already handed to the transmitter
    always_comb begin
        chk_d = chk_q;
        if ((state_q == S_IDLE) && Start) begin
            chk_d = 8'h00;
        end else if ((state_q == S_SEND_HI) || (state_q == S_SEND_LO)) begin
            chk_d = chk_q ^ tx_data_q;
        end else begin
            chk_d = chk_q;
        end
    end
`endif

    // Outputs decoded from the next state so they can be registered without adding latency
    always_comb begin
        mem_rd_d   = (state_d == S_RD_ADDR) || (state_d == S_LATCH);
        mem_addr_d = (state_d == S_RD_ADDR) ? addr_d : mem_addr_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_d)
            S_SEND_HI: begin
                tx_start_d = 1'b1;
                tx_data_d  = word_d[DATA_SIZE-1 -: 8];
            end
            S_SEND_LO: begin
                tx_start_d = 1'b1;
                tx_data_d  = word_d[7:0];
            end
`ifdef DUMP_CHECKSUM_EN
            S_CHK_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = chk_d;
            end
`endif
            default: begin
                tx_start_d = 1'b0;
                tx_data_d  = tx_data_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q      <= {ADDR_BUS{1'b0}};
            remaining_q <= CNT_ZERO;
            word_q      <= {DATA_SIZE{1'b0}};
            mem_addr_q  <= {ADDR_BUS{1'b0}};
            mem_rd_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DUMP_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign Mem_Addr = mem_addr_q;
    assign Mem_Rd   = mem_rd_q;
    assign Tx_Data  = tx_data_q;
    assign Tx_Start = tx_start_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Randomized self-checking bench for mem_dump_unit: memory model, transmitter model and
// an expected byte stream computed directly from the dump rules.
module tb_mem_dump_unit;
    localparam int MEMSZ = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] start_addr = 11'd0;
    logic [11:0] count = 12'd0;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        tx_done_auto = 1'b0;
    logic        tx_done_man = 1'b0;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:MEMSZ-1];

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];
    assign tx_done  = tx_done_auto | tx_done_man;

    mem_dump_unit #(.ADDR_BUS(11), .DATA_SIZE(16)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Start_Addr(start_addr), .Count(count),
        .Mem_Addr(mem_addr), .Mem_Rd(mem_rd), .Mem_Data(mem_data),
        .Tx_Data(tx_data), .Tx_Start(tx_start), .Tx_Done(tx_done),
        .Busy(busy), .Done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Transmitter model: answers each Tx_Start with a Tx_Done pulse tx_delay cycles later
    int tx_delay = 4;
    bit tx_auto_en = 1'b1;
    int cd = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            tx_done_auto = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done_auto = 1'b1;
            end else if (tx_start && tx_auto_en) begin
                cd = tx_delay;
            end
        end
    end

    // Output monitor, sampled on the falling edge
    int          ncyc = 0;
    logic [7:0]  got[$];
    logic [10:0] rd_addrs[$];
    int          done_cnt = 0, done_idx = 0, first_ts = -1, busy_cyc = 0, rd_cyc = 0;
    bit          prev_rd = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (tx_start) begin
                got.push_back(tx_data);
                if (first_ts < 0) first_ts = ncyc;
            end
            if (done) begin
                done_cnt++;
                done_idx = ncyc;
            end
            if (busy) busy_cyc++;
            if (mem_rd) begin
                rd_cyc++;
                if (!prev_rd) rd_addrs.push_back(mem_addr);
            end
            prev_rd = mem_rd;
        end
    end

    task automatic clear_log();
        got.delete();
        rd_addrs.delete();
        done_cnt = 0;
        done_idx = 0;
        first_ts = -1;
        busy_cyc = 0;
        rd_cyc = 0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        for (int k = 0; k < 200 && got.size() < n; k++) begin
            @(posedge clk); #1;
        end
        check_eq(tag, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic run_dump(input logic [10:0] sa, input int cnt, input int dly,
                            input bit repulse, input string tag);
        logic [7:0]  exp[$];
        logic [7:0]  x;
        logic [15:0] w;
        logic [10:0] a;
        int          s_idx;
        bit          pulsed;
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            a = 11'((int'(sa) + i) % MEMSZ);
            w = mem[a];
            exp.push_back(w[15:8]);
            exp.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
`ifdef DUMP_CHECKSUM_EN
        exp.push_back(x);
`endif
        tx_delay = dly;
        @(posedge clk); #1;
        clear_log();
        start = 1'b1;
        start_addr = sa;
        count = 12'(cnt);
        s_idx = ncyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = 11'($urandom);
        count = 12'($urandom);
        pulsed = 1'b0;
        for (int k = 0; k < 40000 && done_cnt == 0; k++) begin
            if (repulse && !pulsed && got.size() == 1) begin
                start = 1'b1;
                start_addr = 11'd9;
                count = 12'd3;
                pulsed = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq({tag, " done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " busy_span"}, 32'(busy_cyc), 32'(done_idx - s_idx));
        check_eq({tag, " busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, " nbytes"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check_eq($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        check_eq({tag, " rd_cycles"}, 32'(rd_cyc), 32'(2 * cnt));
        check_eq({tag, " rd_words"}, 32'(rd_addrs.size()), 32'(cnt));
        for (int i = 0; i < rd_addrs.size() && i < cnt; i++)
            check_eq($sformatf("%s addr%0d", tag, i), 32'(rd_addrs[i]),
                     32'((int'(sa) + i) % MEMSZ));
        if (cnt > 0) begin
            check_eq({tag, " first_tx_lat"}, 32'(first_ts - s_idx), 32'd3);
        end else begin
`ifdef DUMP_CHECKSUM_EN
            check_eq({tag, " chk_tx_lat"}, 32'(first_ts - s_idx), 32'd1);
`else
            check_eq({tag, " done_lat"}, 32'(done_idx - s_idx), 32'd1);
`endif
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        check_eq({tag, " tx_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, " tx_start"}, 32'(tx_start), 32'd0);
        check_eq({tag, " busy"}, 32'(busy), 32'd0);
        check_eq({tag, " done"}, 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        mem[5] = 16'hA1B2;
        mem[6] = 16'hC3D4;
        run_dump(11'd5, 2, 4, 1'b0, "basic");

        mem[11'h7FF] = 16'h1234;
        mem[0] = 16'h5678;
        run_dump(11'h7FF, 2, 2, 1'b0, "wrap");

        run_dump(11'd100, 0, 3, 1'b0, "count0");

        run_dump(11'd5, 2, 4, 1'b1, "restart_ignored");

        // Reset while waiting for the low byte's Tx_Done
        tx_auto_en = 1'b0;
        @(posedge clk); #1;
        clear_log();
        start = 1'b1;
        start_addr = 11'd5;
        count = 12'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_bytes(1, "rst hi_byte");
        repeat (2) @(posedge clk);
        #1;
        tx_done_man = 1'b1;
        @(posedge clk); #1;
        tx_done_man = 1'b0;
        wait_bytes(2, "rst lo_byte");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tx_done_man = 1'b1;
        @(posedge clk); #1;
        tx_done_man = 1'b0;
        check_idle_outputs("after_reset");
        repeat (10) @(posedge clk);
        #1;
        check_eq("after_reset nbytes", 32'(got.size()), 32'd2);
        check_eq("after_reset no_done", 32'(done_cnt), 32'd0);
        check_idle_outputs("after_reset_idle");
        tx_auto_en = 1'b1;
        run_dump(11'd5, 2, 4, 1'b0, "post_reset");

        for (int t = 0; t < 8; t++)
            run_dump(11'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                     1'b0, $sformatf("rand%0d", t));

        run_dump(11'($urandom), MEMSZ, 1, 1'b0, "full_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
